// File: rtl/seg_scan_ctrl_if.sv
// Host-side bundle for the scan controller: scan enable, value load request and the
// registered display/scan outputs consumed by the BCD/7-segment decoder.
interface seg_scan_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  enable;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_hex;

  logic [DATA_WIDTH-1:0] data;
  logic                  isHex;
  logic [2:0]            choice;
  logic [7:0]            an;
  logic                  ack;
  logic                  frame;

  modport master (
    output enable,
    output load,
    output load_data,
    output load_hex,
    input  data,
    input  isHex,
    input  choice,
    input  an,
    input  ack,
    input  frame
  );

  modport slave (
    input  enable,
    input  load,
    input  load_data,
    input  load_hex,
    output data,
    output isHex,
    output choice,
    output an,
    output ack,
    output frame
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: steps a digit index every DIV clocks, drives
// active-low digit enables, and swaps in new display values only between frames.
module seg_scan_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DIV        = 100000
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_ctrl_if.slave scan
);

  localparam int unsigned     PreW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(DIV - 1);

  logic [PreW-1:0]       prescaler_q, prescaler_d;
  logic [2:0]            choice_q, choice_d;
  logic [7:0]            an_q, an_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  is_hex_q, is_hex_d;
  logic                  ack_q, ack_d;
  logic                  frame_q, frame_d;
  logic                  pending_q, pending_d;
  logic [DATA_WIDTH-1:0] shadow_data_q, shadow_data_d;
  logic                  shadow_hex_q, shadow_hex_d;

  logic       tick;
  logic [2:0] last;
  logic       wrap;
  logic       want_apply;
  logic       apply;
  logic       dec_hidden;

  always_comb begin
    tick       = scan.enable && (prescaler_q == PreMax);
    last       = is_hex_q ? 3'd7 : 3'd3;
    wrap       = tick && (choice_q >= last);
    want_apply = pending_q || scan.load;
    // Swap only at a frame boundary, or at once while the display is blanked.
    apply      = want_apply && (wrap || !scan.enable);
    // A disabled-time switch to decimal can leave choice above 3; keep those digits dark.
    dec_hidden = !is_hex_q && choice_q[2];
  end

  // Prescaler and digit index
  always_comb begin
    prescaler_d = prescaler_q;
    choice_d    = choice_q;
    if (scan.enable) begin
      prescaler_d = tick ? '0 : prescaler_q + PreW'(1);
    end
    if (tick) begin
      choice_d = wrap ? 3'd0 : choice_q + 3'd1;
    end
  end

  // Digit enables follow choice by one clock to line up with the decoder's seg register.
  always_comb begin
    an_d = 8'hFF;
    if (scan.enable && !dec_hidden) begin
      an_d = ~(8'b1 << choice_q);
    end
  end

  // Shadow capture and tear-free apply
  always_comb begin
    shadow_data_d = shadow_data_q;
    shadow_hex_d  = shadow_hex_q;
    pending_d     = pending_q;
    data_d        = data_q;
    is_hex_d      = is_hex_q;

    if (scan.load) begin
      shadow_data_d = scan.load_data;
      shadow_hex_d  = scan.load_hex;
      pending_d     = 1'b1;
    end

    if (apply) begin
      data_d    = scan.load ? scan.load_data : shadow_data_q;
      is_hex_d  = scan.load ? scan.load_hex  : shadow_hex_q;
      pending_d = 1'b0;
    end

    ack_d   = apply;
    frame_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_q   <= '0;
      choice_q      <= 3'd0;
      an_q          <= 8'hFF;
      data_q        <= '0;
      is_hex_q      <= 1'b0;
      ack_q         <= 1'b0;
      frame_q       <= 1'b0;
      pending_q     <= 1'b0;
      shadow_data_q <= '0;
      shadow_hex_q  <= 1'b0;
    end else begin
      prescaler_q   <= prescaler_d;
      choice_q      <= choice_d;
      an_q          <= an_d;
      data_q        <= data_d;
      is_hex_q      <= is_hex_d;
      ack_q         <= ack_d;
      frame_q       <= frame_d;
      pending_q     <= pending_d;
      shadow_data_q <= shadow_data_d;
      shadow_hex_q  <= shadow_hex_d;
    end
  end

  assign scan.data   = data_q;
  assign scan.isHex  = is_hex_q;
  assign scan.choice = choice_q;
  assign scan.an     = an_q;
  assign scan.ack    = ack_q;
  assign scan.frame  = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with DIV=4; acks are matched against a queue of
// expected display values pushed when the corresponding load is driven.
module tb_seg_scan_ctrl;

  typedef struct packed {
    logic [31:0] data;
    logic        hex;
  } exp_t;

  logic clk;
  logic clk_en;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  seg_scan_ctrl_if #(.DATA_WIDTH(32)) bus ();

  seg_scan_ctrl #(
    .DATA_WIDTH(32),
    .DIV       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .scan(bus)
  );

  always #5 if (clk_en) clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1);
  end

  task automatic ack_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.ack === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: ack=1 data=%h isHex=%b, required no ack", bus.data,
                   bus.isHex);
        end else begin
          e = exp_q.pop_front();
          if (bus.data !== e.data || bus.isHex !== e.hex) begin
            errors++;
            $display("FAIL ack_value: data=%h isHex=%b, required data=%h isHex=%b", bus.data,
                     bus.isHex, e.data, e.hex);
          end
        end
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ack_timeout: %0d expected acks outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.enable    = 1'b0;
    bus.load      = 1'b0;
    bus.load_data = '0;
    bus.load_hex  = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Load while disabled so the value applies on the next edge.
  task automatic setup_mode(input logic hex, input logic [31:0] val);
    bus.enable    = 1'b0;
    @(negedge clk);
    bus.load      = 1'b1;
    bus.load_data = val;
    bus.load_hex  = hex;
    exp_q.push_back('{data: val, hex: hex});
    @(negedge clk);
    bus.load = 1'b0;
    wait_drain(4);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.choice !== 3'd0 || bus.an !== 8'hFF || bus.data !== 32'h0 || bus.isHex !== 1'b0 ||
        bus.ack !== 1'b0 || bus.frame !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: choice=%h an=%h data=%h isHex=%b ack=%b frame=%b, required 0 FF 0 0 0 0",
               bus.choice, bus.an, bus.data, bus.isHex, bus.ack, bus.frame);
    end
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_dec_scan();
    logic [2:0] ec;
    logic [7:0] ea;
    logic       ef;
    do_reset();
    bus.enable = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      ec = 3'((c / 4) % 4);
      ea = ~(8'b1 << 3'(((c - 1) / 4) % 4));
      ef = (c % 16 == 0);
      checks++;
      if (bus.choice !== ec || bus.an !== ea || bus.frame !== ef) begin
        errors++;
        $display("FAIL dec_scan c=%0d: choice=%0d an=%h frame=%b, required %0d %h %b", c,
                 bus.choice, bus.an, bus.frame, ec, ea, ef);
      end
    end
  endtask

  task automatic test_hex_scan();
    logic [2:0] ec;
    logic [7:0] ea;
    logic       ef;
    do_reset();
    setup_mode(1'b1, 32'h0);
    checks++;
    if (bus.an !== 8'hFF || bus.isHex !== 1'b1) begin
      errors++;
      $display("FAIL hex_setup: an=%h isHex=%b, required FF 1", bus.an, bus.isHex);
    end
    bus.enable = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      ec = 3'((c / 4) % 8);
      ea = ~(8'b1 << 3'(((c - 1) / 4) % 8));
      ef = (c % 32 == 0);
      checks++;
      if (bus.choice !== ec || bus.an !== ea || bus.frame !== ef) begin
        errors++;
        $display("FAIL hex_scan c=%0d: choice=%0d an=%h frame=%b, required %0d %h %b", c,
                 bus.choice, bus.an, bus.frame, ec, ea, ef);
      end
    end
  endtask

  task automatic test_tear_free();
    do_reset();
    setup_mode(1'b1, 32'h0);
    bus.enable = 1'b1;
    for (int c = 1; c <= 52; c++) begin
      @(negedge clk);
      bus.load = 1'b0;
      if (c == 8 || c == 20) begin
        checks++;
        if (bus.choice !== ((c == 8) ? 3'd2 : 3'd5)) begin
          errors++;
          $display("FAIL tear_pos c=%0d: choice=%0d", c, bus.choice);
        end
      end
      if (c == 8) begin
        bus.load      = 1'b1;
        bus.load_data = 32'h1234ABCD;
        bus.load_hex  = 1'b1;
      end else if (c == 20) begin
        bus.load      = 1'b1;
        bus.load_data = 32'h0000FFFF;
        bus.load_hex  = 1'b0;
        // Newest load wins, so only its value is expected at the wrap.
        exp_q.push_back('{data: 32'h0000FFFF, hex: 1'b0});
      end
      if (c < 32 && c % 4 == 1) begin
        checks++;
        if (bus.data !== 32'h0 || bus.isHex !== 1'b1) begin
          errors++;
          $display("FAIL tear_hold c=%0d: data=%h isHex=%b, required 0 1", c, bus.data, bus.isHex);
        end
      end
      if (c == 32) begin
        checks++;
        if (bus.data !== 32'h0000FFFF || bus.isHex !== 1'b0 || bus.ack !== 1'b1) begin
          errors++;
          $display("FAIL tear_apply: data=%h isHex=%b ack=%b, required 0000FFFF 0 1", bus.data,
                   bus.isHex, bus.ack);
        end
      end
      if (c > 32) begin
        checks++;
        if (bus.choice > 3'd3 || bus.frame !== (c == 48)) begin
          errors++;
          $display("FAIL tear_dec_frame c=%0d: choice=%0d frame=%b, required choice<=3 frame=%b",
                   c, bus.choice, bus.frame, (c == 48));
        end
      end
    end
    wait_drain(4);
  endtask

  task automatic test_disabled_load();
    logic [2:0] ec;
    do_reset();
    setup_mode(1'b1, 32'h0);
    bus.enable = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (bus.choice !== 3'd5) begin
      errors++;
      $display("FAIL dis_pos: choice=%0d, required 5", bus.choice);
    end
    bus.enable = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.an !== 8'hFF || bus.choice !== 3'd5) begin
      errors++;
      $display("FAIL dis_blank: an=%h choice=%0d, required FF 5", bus.an, bus.choice);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.choice !== 3'd5 || bus.an !== 8'hFF) begin
      errors++;
      $display("FAIL dis_hold: choice=%0d an=%h, required 5 FF", bus.choice, bus.an);
    end
    bus.load      = 1'b1;
    bus.load_data = 32'h55;
    bus.load_hex  = 1'b1;
    exp_q.push_back('{data: 32'h55, hex: 1'b1});
    @(negedge clk);
    bus.load = 1'b0;
    checks++;
    if (bus.data !== 32'h55 || bus.ack !== 1'b1) begin
      errors++;
      $display("FAIL dis_load: data=%h ack=%b, required 55 1", bus.data, bus.ack);
    end
    wait_drain(4);
    bus.enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      ec = (k < 4) ? 3'd5 : 3'd6;
      checks++;
      if (bus.choice !== ec || bus.an !== 8'hDF) begin
        errors++;
        $display("FAIL dis_resume k=%0d: choice=%0d an=%h, required %0d DF", k, bus.choice,
                 bus.an, ec);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.enable = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      bus.load = 1'b0;
      if (c == 5 || c == 9) begin
        bus.load      = 1'b1;
        bus.load_data = 32'h11111111 * c;
        bus.load_hex  = 1'b0;
      end else if (c == 15) begin
        bus.load      = 1'b1;
        bus.load_data = 32'hA5A5A5A5;
        bus.load_hex  = 1'b1;
        exp_q.push_back('{data: 32'hA5A5A5A5, hex: 1'b1});
      end
      if (c == 12) begin
        checks++;
        if (bus.data !== 32'h0) begin
          errors++;
          $display("FAIL b2b_hold: data=%h, required 0", bus.data);
        end
      end
      if (c == 16) begin
        checks++;
        if (bus.data !== 32'hA5A5A5A5 || bus.isHex !== 1'b1 || bus.choice !== 3'd0 ||
            bus.frame !== 1'b1) begin
          errors++;
          $display("FAIL b2b_wrap_load: data=%h isHex=%b choice=%0d frame=%b, required A5A5A5A5 1 0 1",
                   bus.data, bus.isHex, bus.choice, bus.frame);
        end
      end
    end
    checks++;
    if (bus.choice !== 3'd4) begin
      errors++;
      $display("FAIL b2b_hex_frame: choice=%0d, required 4", bus.choice);
    end
    wait_drain(4);
  endtask

  task automatic test_reset_mid();
    do_reset();
    setup_mode(1'b1, 32'h0);
    bus.enable = 1'b1;
    repeat (24) @(negedge clk);
    checks++;
    if (bus.choice !== 3'd6) begin
      errors++;
      $display("FAIL rmid_pos: choice=%0d, required 6", bus.choice);
    end
    bus.load      = 1'b1;
    bus.load_data = 32'hDEADBEEF;
    bus.load_hex  = 1'b0;
    @(negedge clk);
    bus.load = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.choice !== 3'd0 || bus.an !== 8'hFF || bus.data !== 32'h0 || bus.isHex !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async: choice=%0d an=%h data=%h isHex=%b, required 0 FF 0 0",
               bus.choice, bus.an, bus.data, bus.isHex);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c % 8 == 0) begin
        checks++;
        if (bus.data !== 32'h0) begin
          errors++;
          $display("FAIL rmid_discard c=%0d: data=%h, required 0", c, bus.data);
        end
      end
    end
  endtask

  initial begin
    clk           = 1'b0;
    clk_en        = 1'b0;
    rst           = 1'b0;
    checks        = 0;
    errors        = 0;
    bus.enable    = 1'b0;
    bus.load      = 1'b0;
    bus.load_data = '0;
    bus.load_hex  = 1'b0;
    fork
      ack_monitor();
    join_none
    test_reset();
    test_dec_scan();
    test_hex_scan();
    test_tear_free();
    test_disabled_load();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
